sdram_arbit: RTL and testbench

//   Command arbiter between the SDRAM engines (sdram_init, auto-refresh, sdram_write, sdram_read) and the device pins.

---
 rtl/sdram_arbit_pkg.sv | 18 +
 rtl/sdram_arbit.sv | 178 +++++++++++++++++
 tb/tb_sdram_arbit.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/sdram_arbit_pkg.sv
// Shared constants for the SDRAM command arbiter: widths, command encodings and state codes.
// Imported by the arbiter and available to anything that decodes its debug state.
package sdram_arbit_pkg;

    localparam int ARB_DATA_W = 16;
    localparam int ARB_ADDR_W = 13;
    localparam int ARB_BANK_W = 2;

    // {cs_n, ras_n, cas_n, we_n}
    localparam logic [3:0] CMD_NOP = 4'b0111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ARBIT = 3'd1;
    localparam logic [2:0] S_AREF  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_READ  = 3'd4;

endpackage : sdram_arbit_pkg

// File: rtl/sdram_arbit.sv
// Grants the SDRAM pins to one engine at a time (refresh > write > read) and
// routes the owner's command/bank/address to the device, driving DQ during writes.
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter int DATA_W = ARB_DATA_W,
    parameter int ADDR_W = ARB_ADDR_W,
    parameter int BANK_W = ARB_BANK_W
) (
    input  logic              arb_clk,
    input  logic              arb_rst_n,

    input  logic              init_end,
    input  logic [3:0]        init_cmd,
    input  logic [BANK_W-1:0] init_bank,
    input  logic [ADDR_W-1:0] init_addr,

    input  logic              aref_req,
    input  logic              aref_end,
    input  logic [3:0]        aref_cmd,
    input  logic [BANK_W-1:0] aref_bank,
    input  logic [ADDR_W-1:0] aref_addr,

    input  logic              wr_req,
    input  logic              wr_end,
    input  logic              wr_sdram_en,
    input  logic [3:0]        wr_cmd,
    input  logic [BANK_W-1:0] wr_bank,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,

    input  logic              rd_req,
    input  logic              rd_end,
    input  logic [3:0]        rd_cmd,
    input  logic [BANK_W-1:0] rd_bank,
    input  logic [ADDR_W-1:0] rd_addr,

    output logic              aref_en,
    output logic              wr_en,
    output logic              rd_en,

    output logic              sdram_cke,
    output logic              sdram_cs_n,
    output logic              sdram_ras_n,
    output logic              sdram_cas_n,
    output logic              sdram_we_n,
    output logic [BANK_W-1:0] sdram_ba,
    output logic [ADDR_W-1:0] sdram_addr,
    inout  wire  [DATA_W-1:0] sdram_dq,

    output logic [2:0]        arb_state_o
);

    logic [2:0]        state_q, state_d;
    logic              aref_en_q, aref_en_d;
    logic              wr_en_q, wr_en_d;
    logic              rd_en_q, rd_en_d;
    logic [3:0]        cmd_s;
    logic [BANK_W-1:0] ba_s;
    logic [ADDR_W-1:0] addr_s;

    // Grants are registered alongside the state so each *_en rises on the
    // same edge the owner is recorded and falls on the edge its *_end is seen.
    always_comb begin
        state_d   = state_q;
        aref_en_d = aref_en_q;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        case (state_q)
            S_IDLE: begin
                if (init_end) state_d = S_ARBIT;
            end
            S_ARBIT: begin
                if (aref_req) begin
                    state_d   = S_AREF;
                    aref_en_d = 1'b1;
                end else if (wr_req) begin
                    state_d = S_WRITE;
                    wr_en_d = 1'b1;
                end else if (rd_req) begin
                    state_d = S_READ;
                    rd_en_d = 1'b1;
                end
            end
            S_AREF: begin
                if (aref_end) begin
                    state_d   = S_ARBIT;
                    aref_en_d = 1'b0;
                end
            end
            S_WRITE: begin
                if (wr_end) begin
                    state_d = S_ARBIT;
                    wr_en_d = 1'b0;
                end
            end
            S_READ: begin
                if (rd_end) begin
                    state_d = S_ARBIT;
                    rd_en_d = 1'b0;
                end
            end
            default: begin
                state_d   = S_IDLE;
                aref_en_d = 1'b0;
                wr_en_d   = 1'b0;
                rd_en_d   = 1'b0;
            end
        endcase
        // Losing initialisation overrides everything and drops the bus back to the init engine.
        if (!init_end) begin
            state_d   = S_IDLE;
            aref_en_d = 1'b0;
            wr_en_d   = 1'b0;
            rd_en_d   = 1'b0;
        end
    end

    always_ff @(posedge arb_clk or negedge arb_rst_n) begin
        if (!arb_rst_n) begin
            state_q   <= S_IDLE;
            aref_en_q <= 1'b0;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            aref_en_q <= aref_en_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
        end
    end

    // Pin mux follows the registered state only, so an async reset switches the pins immediately.
    always_comb begin
        cmd_s  = CMD_NOP;
        ba_s   = '0;
        addr_s = '0;
        case (state_q)
            S_IDLE: begin
                cmd_s  = init_cmd;
                ba_s   = init_bank;
                addr_s = init_addr;
            end
            S_AREF: begin
                cmd_s  = aref_cmd;
                ba_s   = aref_bank;
                addr_s = aref_addr;
            end
            S_WRITE: begin
                cmd_s  = wr_cmd;
                ba_s   = wr_bank;
                addr_s = wr_addr;
            end
            S_READ: begin
                cmd_s  = rd_cmd;
                ba_s   = rd_bank;
                addr_s = rd_addr;
            end
            default: begin
                cmd_s  = CMD_NOP;
                ba_s   = '0;
                addr_s = '0;
            end
        endcase
    end

    assign {sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n} = cmd_s;
    assign sdram_cke   = 1'b1;
    assign sdram_ba    = ba_s;
    assign sdram_addr  = addr_s;
    assign sdram_dq    = (state_q == S_WRITE && wr_sdram_en) ? wr_data : {DATA_W{1'bz}};

    assign aref_en     = aref_en_q;
    assign wr_en       = wr_en_q;
    assign rd_en       = rd_en_q;
    assign arb_state_o = state_q;

endmodule : sdram_arbit

// File: tb/tb_sdram_arbit.sv
// Directed bench for sdram_arbit: grant order, pin routing, DQ ownership,
// spurious end pulses, init_end loss and asynchronous reset mid-write.
module tb_sdram_arbit;
    import sdram_arbit_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_bank;
    logic [12:0] init_addr;
    logic        aref_req, aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_bank;
    logic [12:0] aref_addr;
    logic        wr_req, wr_end, wr_sdram_en;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_bank;
    logic [12:0] wr_addr;
    logic [15:0] wr_data;
    logic        rd_req, rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_bank;
    logic [12:0] rd_addr;
    logic        aref_en, wr_en, rd_en;
    logic        sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    wire  [15:0] sdram_dq;
    logic [2:0]  arb_state;

    int n_assert = 0;
    int n_fail   = 0;

    // Released DQ reads as all ones; written data is chosen never to be all ones.
    pullup pu_dq (sdram_dq);

    sdram_arbit dut (
        .arb_clk(clk), .arb_rst_n(rst_n),
        .init_end(init_end), .init_cmd(init_cmd), .init_bank(init_bank), .init_addr(init_addr),
        .aref_req(aref_req), .aref_end(aref_end), .aref_cmd(aref_cmd), .aref_bank(aref_bank),
        .aref_addr(aref_addr),
        .wr_req(wr_req), .wr_end(wr_end), .wr_sdram_en(wr_sdram_en), .wr_cmd(wr_cmd),
        .wr_bank(wr_bank), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_req(rd_req), .rd_end(rd_end), .rd_cmd(rd_cmd), .rd_bank(rd_bank), .rd_addr(rd_addr),
        .aref_en(aref_en), .wr_en(wr_en), .rd_en(rd_en),
        .sdram_cke(sdram_cke), .sdram_cs_n(sdram_cs_n), .sdram_ras_n(sdram_ras_n),
        .sdram_cas_n(sdram_cas_n), .sdram_we_n(sdram_we_n), .sdram_ba(sdram_ba),
        .sdram_addr(sdram_addr), .sdram_dq(sdram_dq), .arb_state_o(arb_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Checks grants, pin command/bank/address together.
    task automatic chk_bus(input string tag, input logic [2:0] en, input logic [3:0] cmd,
                           input logic [1:0] ba, input logic [12:0] addr);
        chk({tag, "_en"}, {29'd0, aref_en, wr_en, rd_en}, {29'd0, en});
        chk({tag, "_cmd"}, {28'd0, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n}, {28'd0, cmd});
        chk({tag, "_ba"}, {30'd0, sdram_ba}, {30'd0, ba});
        chk({tag, "_addr"}, {19'd0, sdram_addr}, {19'd0, addr});
    endtask

    initial begin
        rst_n = 1'b0; init_end = 1'b0;
        init_cmd = 4'b0010; init_bank = 2'd1; init_addr = 13'h0400;
        aref_req = 0; aref_end = 0; aref_cmd = 4'b0001; aref_bank = 2'd2; aref_addr = 13'h00AA;
        wr_req = 0; wr_end = 0; wr_sdram_en = 0; wr_cmd = 4'b0100; wr_bank = 2'd3;
        wr_addr = 13'h0123; wr_data = 16'hA5A5;
        rd_req = 0; rd_end = 0; rd_cmd = 4'b0101; rd_bank = 2'd1; rd_addr = 13'h0456;

        // Reset held 10 cycles: pins follow the init engine, no grants, DQ released.
        repeat (10) tick();
        chk_bus("rst", 3'b000, 4'b0010, 2'd1, 13'h0400);
        chk("rst_cke", {31'd0, sdram_cke}, 32'd1);
        chk("rst_dq", {16'd0, sdram_dq}, 32'h0000FFFF);
        chk("rst_state", {29'd0, arb_state}, {29'd0, S_IDLE});
        rst_n = 1'b1;
        tick();
        chk_bus("idle_hold", 3'b000, 4'b0010, 2'd1, 13'h0400);

        // Init completes with a write pending: one NOP cycle, then the write is granted.
        init_end = 1'b1; wr_req = 1'b1;
        tick();
        chk_bus("arbit1", 3'b000, 4'b0111, 2'd0, 13'h0000);
        tick();
        chk_bus("wr_grant", 3'b010, 4'b0100, 2'd3, 13'h0123);
        chk("wr_dq_off", {16'd0, sdram_dq}, 32'h0000FFFF);
        wr_req = 1'b0; wr_sdram_en = 1'b1;
        #1;
        chk("wr_dq_on", {16'd0, sdram_dq}, 32'h0000A5A5);
        wr_data = 16'h1234;
        #1;
        chk("wr_dq_on2", {16'd0, sdram_dq}, 32'h00001234);
        wr_end = 1'b1;
        tick();
        wr_end = 1'b0; wr_sdram_en = 1'b0;
        #1;
        chk_bus("wr_done", 3'b000, 4'b0111, 2'd0, 13'h0000);
        chk("wr_done_dq", {16'd0, sdram_dq}, 32'h0000FFFF);
        tick();
        chk_bus("arbit_idle", 3'b000, 4'b0111, 2'd0, 13'h0000);

        // All three requests together: refresh, then write, then read, each after a NOP.
        aref_req = 1'b1; wr_req = 1'b1; rd_req = 1'b1;
        tick();
        chk_bus("aref_grant", 3'b100, 4'b0001, 2'd2, 13'h00AA);
        aref_req = 1'b0; aref_end = 1'b1;
        tick();
        aref_end = 1'b0;
        chk_bus("aref_done", 3'b000, 4'b0111, 2'd0, 13'h0000);
        tick();
        chk_bus("wr_second", 3'b010, 4'b0100, 2'd3, 13'h0123);
        wr_req = 1'b0; wr_end = 1'b1;
        tick();
        wr_end = 1'b0;
        chk_bus("wr_second_done", 3'b000, 4'b0111, 2'd0, 13'h0000);
        tick();
        chk_bus("rd_grant", 3'b001, 4'b0101, 2'd1, 13'h0456);
        rd_req = 1'b0;

        // Ends from non-owners are ignored while reading.
        wr_end = 1'b1; aref_end = 1'b1;
        tick();
        wr_end = 1'b0; aref_end = 1'b0;
        chk_bus("rd_spurious", 3'b001, 4'b0101, 2'd1, 13'h0456);
        chk("rd_state", {29'd0, arb_state}, {29'd0, S_READ});

        // Refresh requested mid-read waits for rd_end, then wins two edges later.
        aref_req = 1'b1;
        tick();
        chk_bus("rd_no_preempt", 3'b001, 4'b0101, 2'd1, 13'h0456);
        rd_end = 1'b1;
        tick();
        rd_end = 1'b0;
        chk_bus("rd_done", 3'b000, 4'b0111, 2'd0, 13'h0000);
        tick();
        chk_bus("aref_after_rd", 3'b100, 4'b0001, 2'd2, 13'h00AA);
        aref_req = 1'b0;

        // Losing init_end during refresh returns the bus to the init engine.
        init_end = 1'b0;
        tick();
        chk_bus("init_lost", 3'b000, 4'b0010, 2'd1, 13'h0400);
        init_end = 1'b1; wr_req = 1'b1;
        tick();
        chk("reinit_arbit", {29'd0, arb_state}, {29'd0, S_ARBIT});
        tick();
        wr_sdram_en = 1'b1; wr_data = 16'h0F0F;
        #1;
        chk("wr3_dq", {16'd0, sdram_dq}, 32'h00000F0F);
        chk("wr3_en", {31'd0, wr_en}, 32'd1);

        // Asynchronous reset mid-write takes effect without a clock edge.
        #1;
        rst_n = 1'b0;
        #1;
        chk_bus("async_rst", 3'b000, 4'b0010, 2'd1, 13'h0400);
        chk("async_rst_dq", {16'd0, sdram_dq}, 32'h0000FFFF);
        chk("async_rst_state", {29'd0, arb_state}, {29'd0, S_IDLE});

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule : tb_sdram_arbit
